// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: lw/sw, beq/bne, j, R-type add/sub/and, addi/addiu,
// memory wait states set by MEM_WAIT, overflow and undefined-instruction traps.
module multicycle_control_unit #(
  parameter int MEM_WAIT  = 2,
  parameter int VEC_SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           OpCode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 overflow,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MDRWrite,
  output logic                 A_Control,
  output logic                 B_Control,
  output logic                 ALUOutControl,
  output logic                 RegControl,
  output logic                 EPCWrite,
  output logic                 MemCtrl,
  output logic [1:0]           IorD,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [2:0]           ALUControl,
  output logic [2:0]           PCSource,
  output logic [2:0]           RegDst,
  output logic [3:0]           DataSrc,
  output logic [VEC_SEL_W-1:0] ExcCause,
  output logic [6:0]           estado
);

  typedef enum logic [6:0] {
    S_RST      = 7'd0,
    S_FETCH    = 7'd1,
    S_FETCH_PC = 7'd2,
    S_DECODE   = 7'd3,
    S_EXEC_R   = 7'd4,
    S_EXEC_I   = 7'd5,
    S_WB_R     = 7'd6,
    S_WB_I     = 7'd7,
    S_ADDR     = 7'd8,
    S_MEM_RD   = 7'd9,
    S_MEM_WB   = 7'd10,
    S_MEM_WR   = 7'd11,
    S_BRANCH   = 7'd12,
    S_JUMP     = 7'd13,
    S_EXC_EPC  = 7'd14,
    S_EXC_VEC  = 7'd15
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       mdr_write;
    logic       a_en;
    logic       b_en;
    logic       aluout_en;
    logic       reg_en;
    logic       epc_en;
    logic       mem_write;
    logic [1:0] iord;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] pc_source;
    logic [2:0] reg_dst;
    logic [3:0] data_src;
  } ctrl_t;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t               state_r;
  state_t               state_next_s;
  logic [3:0]           wait_r;
  logic [3:0]           wait_next_s;
  logic [VEC_SEL_W-1:0] cause_r;
  logic [VEC_SEL_W-1:0] cause_next_s;
  ctrl_t                ctrl_r;
  logic                 branch_take_s;
  logic                 funct_ok_s;

  // Control word for a state; fin marks the final cycle of a wait-stretched state.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic fin, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = 3'b001;
        c.ir_write  = fin;
      end
      S_FETCH_PC: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = 3'b001;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.a_en      = 1'b1;
        c.b_en      = 1'b1;
        c.aluout_en = 1'b1;
        c.alu_src_b = 2'b11;
        c.alu_op    = 3'b001;
      end
      S_EXEC_R: begin
        c.alu_src_a = 2'b01;
        c.aluout_en = 1'b1;
        case (fn)
          6'b100000: c.alu_op = 3'b001;
          6'b100010: c.alu_op = 3'b010;
          6'b100100: c.alu_op = 3'b011;
          default:   c.alu_op = 3'b001;
        endcase
      end
      S_EXEC_I, S_ADDR: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.alu_op    = 3'b001;
        c.aluout_en = 1'b1;
      end
      S_WB_R: begin
        c.reg_en  = 1'b1;
        c.reg_dst = 3'b001;
      end
      S_WB_I: c.reg_en = 1'b1;
      S_MEM_RD: begin
        c.iord      = 2'b01;
        c.mdr_write = fin;
      end
      S_MEM_WB: begin
        c.reg_en   = 1'b1;
        c.data_src = 4'b0001;
      end
      S_MEM_WR: begin
        c.iord      = 2'b01;
        c.mem_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 2'b01;
        c.alu_op    = 3'b010;
        c.pc_source = 3'b001;
      end
      S_JUMP: begin
        c.pc_source = 3'b010;
        c.pc_write  = 1'b1;
      end
      S_EXC_EPC: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = 3'b010;
        c.epc_en    = 1'b1;
      end
      S_EXC_VEC: begin
        c.pc_source = 3'b011;
        c.pc_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state, next wait count and trap cause selection.
  always_comb begin
    state_next_s = state_r;
    cause_next_s = cause_r;
    funct_ok_s   = (funct == 6'b100000) || (funct == 6'b100010) || (funct == 6'b100100);
    case (state_r)
      S_RST:      state_next_s = S_FETCH;
      S_FETCH: begin
        if (wait_r == WAIT_LAST) state_next_s = S_FETCH_PC;
        else                     state_next_s = S_FETCH;
      end
      S_FETCH_PC: state_next_s = S_DECODE;
      S_DECODE: begin
        case (OpCode)
          6'b000000: begin
            if (funct_ok_s) begin
              state_next_s = S_EXEC_R;
            end else begin
              state_next_s = S_EXC_EPC;
              cause_next_s = VEC_SEL_W'(1);
            end
          end
          6'b001000, 6'b001001: state_next_s = S_EXEC_I;
          6'b100011, 6'b101011: state_next_s = S_ADDR;
          6'b000100, 6'b000101: state_next_s = S_BRANCH;
          6'b000010:            state_next_s = S_JUMP;
          default: begin
            state_next_s = S_EXC_EPC;
            cause_next_s = VEC_SEL_W'(1);
          end
        endcase
      end
      S_EXEC_R: begin
        // and cannot overflow; add and sub trap on signed overflow
        if (overflow && (funct != 6'b100100)) begin
          state_next_s = S_EXC_EPC;
          cause_next_s = VEC_SEL_W'(0);
        end else begin
          state_next_s = S_WB_R;
        end
      end
      S_EXEC_I: begin
        if (overflow && (OpCode == 6'b001000)) begin
          state_next_s = S_EXC_EPC;
          cause_next_s = VEC_SEL_W'(0);
        end else begin
          state_next_s = S_WB_I;
        end
      end
      S_ADDR: begin
        if (OpCode == 6'b100011) state_next_s = S_MEM_RD;
        else                     state_next_s = S_MEM_WR;
      end
      S_MEM_RD: begin
        if (wait_r == WAIT_LAST) state_next_s = S_MEM_WB;
        else                     state_next_s = S_MEM_RD;
      end
      S_MEM_WR: begin
        if (wait_r == WAIT_LAST) state_next_s = S_FETCH;
        else                     state_next_s = S_MEM_WR;
      end
      S_MEM_WB, S_WB_R, S_WB_I, S_BRANCH, S_JUMP: state_next_s = S_FETCH;
      S_EXC_EPC:  state_next_s = S_EXC_VEC;
      S_EXC_VEC:  state_next_s = S_FETCH;
      default:    state_next_s = S_RST;
    endcase
    if (state_next_s != state_r) wait_next_s = 4'd0;
    else                         wait_next_s = wait_r + 4'd1;
  end

  // State, wait counter, cause and the control word registered from the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_RST;
      wait_r  <= 4'd0;
      cause_r <= '0;
      ctrl_r  <= '0;
    end else begin
      state_r <= state_next_s;
      wait_r  <= wait_next_s;
      cause_r <= cause_next_s;
      ctrl_r  <= decode_ctrl(state_next_s, wait_next_s == WAIT_LAST, funct);
    end
  end

  assign branch_take_s = (OpCode == 6'b000100) ? zero : !zero;

  assign PCWrite       = (state_r == S_BRANCH) ? branch_take_s : ctrl_r.pc_write;
  assign IRWrite       = ctrl_r.ir_write;
  assign MDRWrite      = ctrl_r.mdr_write;
  assign A_Control     = ctrl_r.a_en;
  assign B_Control     = ctrl_r.b_en;
  assign ALUOutControl = ctrl_r.aluout_en;
  assign RegControl    = ctrl_r.reg_en;
  assign EPCWrite      = ctrl_r.epc_en;
  assign MemCtrl       = ctrl_r.mem_write;
  assign IorD          = ctrl_r.iord;
  assign ALUSrcA       = ctrl_r.alu_src_a;
  assign ALUSrcB       = ctrl_r.alu_src_b;
  assign ALUControl    = ctrl_r.alu_op;
  assign PCSource      = ctrl_r.pc_source;
  assign RegDst        = ctrl_r.reg_dst;
  assign DataSrc       = ctrl_r.data_src;
  assign ExcCause      = cause_r;
  assign estado        = state_r;

endmodule
